can_tx_scheduler: RTL

Transmit mailbox scheduler for the CAN controller. Holds NUM_MB pending frames written by the host side, selects the highest-priority one by CAN rules (lowest identifier wins), launches it into the transmit container with a start/busy/done handshake, and re-queues frames that lose bus arbitration. Sits between the host write port and the transmit container, in the `clk` domain.

---
 rtl/can_pkg.sv | 14 +
 rtl/can_prio_select.sv | 32 +++
 rtl/can_tx_scheduler.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// Shared CAN controller definitions: default field widths and the transmit scheduler state type.
package can_pkg;

  localparam int unsigned CAN_ID_W   = 11;
  localparam int unsigned CAN_DATA_W = 64;

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StLaunch,
    StWait
  } sched_state_e;

endpackage

// File: rtl/can_prio_select.sv
// Combinational CAN priority reduction: lowest identifier among pending mailboxes wins,
// ties go to the lowest mailbox index.
module can_prio_select
  import can_pkg::*;
#(
  parameter int unsigned NUM_MB = 4,
  parameter int unsigned ID_W   = CAN_ID_W,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [NUM_MB-1:0]           pending,
  input  logic [NUM_MB-1:0][ID_W-1:0] ids,
  output logic [IDX_W-1:0]            win_idx,
  output logic                        win_valid
);

  logic [ID_W-1:0] best_id;

  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    best_id   = '0;
    // Strict less-than keeps the earlier (lower) index on equal identifiers.
    for (int i = 0; i < NUM_MB; i++) begin
      if (pending[i] && (!win_valid || ids[i] < best_id)) begin
        win_idx   = IDX_W'(i);
        win_valid = 1'b1;
        best_id   = ids[i];
      end
    end
  end

endmodule

// File: rtl/can_tx_scheduler.sv
// CAN transmit mailbox scheduler: priority launch, arbitration-loss requeue, abort and completion
// reporting. Define CAN_TX_SCHED_RETRY_LIMIT_EN to drop frames after RETRY_MAX arbitration losses.
module can_tx_scheduler
  import can_pkg::*;
#(
  parameter int unsigned NUM_MB    = 4,
  parameter int unsigned ID_W      = CAN_ID_W,
  parameter int unsigned DATA_W    = CAN_DATA_W,
  parameter int unsigned RETRY_MAX = 15
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              wr_en,
  input  logic [2:0]        wr_idx,
  input  logic [ID_W-1:0]   wr_id,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [NUM_MB-1:0] abort,
  input  logic              tx_busy,
  input  logic              tx_done,
  input  logic              tx_arb_lost,
  output logic              tx_start,
  output logic [ID_W-1:0]   tx_id,
  output logic [DATA_W-1:0] tx_data,
  output logic [NUM_MB-1:0] mb_pending,
  output logic              done_valid,
  output logic [2:0]        done_idx,
  output logic              done_ok
);

  localparam int unsigned IDX_W = $clog2(NUM_MB);

  if (NUM_MB < 2 || NUM_MB > 8 || RETRY_MAX > 15) begin : g_bad_params
    $error("can_tx_scheduler: NUM_MB must be 2..8 and RETRY_MAX at most 15");
  end

  sched_state_e                  state_q, state_d;
  logic [NUM_MB-1:0][ID_W-1:0]   id_q, id_d;
  logic [NUM_MB-1:0][DATA_W-1:0] data_q, data_d;
  logic [NUM_MB-1:0]             pend_q, pend_d, rpt_q, rpt_d;
  logic [IDX_W-1:0]              cur_q, cur_d;
  logic                          cur_abort_q, cur_abort_d;
  logic                          miss_q, miss_d;
  logic                          sh_valid_q, sh_valid_d;
  logic [ID_W-1:0]               sh_id_q, sh_id_d;
  logic [DATA_W-1:0]             sh_data_q, sh_data_d;
  logic [ID_W-1:0]               tx_id_q, tx_id_d;
  logic [DATA_W-1:0]             tx_data_q, tx_data_d;
  logic                          done_valid_q, done_valid_d;
  logic                          done_ok_q, done_ok_d;
  logic [IDX_W-1:0]              done_idx_q, done_idx_d;
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
  logic [NUM_MB-1:0][3:0]        retry_q, retry_d;
`endif

  logic [IDX_W-1:0]  sel_idx, act_idx, wr_sel, pick;
  logic              sel_valid, active, in_flight, wr_ok, wr_act;
  logic              fin, fin_ok, retry_drop, abort_cur;
  logic [NUM_MB-1:0] sel_mask, abort_hit, queue;

  // A mailbox being aborted this cycle is not eligible for selection.
  assign sel_mask  = pend_q & ~abort;
  assign in_flight = (state_q == StLaunch) || (state_q == StWait);
  assign active    = in_flight || ((state_q == StSelect) && sel_valid);
  assign act_idx   = (state_q == StSelect) ? sel_idx : cur_q;
  assign wr_ok     = wr_en && (32'(wr_idx) < NUM_MB);
  assign wr_sel    = wr_idx[IDX_W-1:0];
  assign wr_act    = wr_ok && active && (wr_sel == act_idx);

  can_prio_select #(
    .NUM_MB(NUM_MB),
    .ID_W  (ID_W),
    .IDX_W (IDX_W)
  ) u_prio_select (
    .pending  (sel_mask),
    .ids      (id_q),
    .win_idx  (sel_idx),
    .win_valid(sel_valid)
  );

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    data_d       = data_q;
    pend_d       = pend_q;
    rpt_d        = rpt_q;
    cur_d        = cur_q;
    cur_abort_d  = cur_abort_q;
    miss_d       = miss_q;
    sh_valid_d   = sh_valid_q;
    sh_id_d      = sh_id_q;
    sh_data_d    = sh_data_q;
    tx_id_d      = tx_id_q;
    tx_data_d    = tx_data_q;
    done_valid_d = 1'b0;
    done_idx_d   = done_idx_q;
    done_ok_d    = done_ok_q;
    fin          = 1'b0;
    fin_ok       = 1'b0;
    retry_drop   = 1'b0;
    pick         = '0;
    abort_hit    = '0;
    queue        = '0;
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
    retry_d      = retry_q;
`endif

    for (int i = 0; i < NUM_MB; i++) begin
      if (abort[i] && pend_q[i] && !(active && (IDX_W'(i) == act_idx)) &&
          !(wr_ok && (IDX_W'(i) == wr_sel))) begin
        abort_hit[i] = 1'b1;
      end
    end
    abort_cur = in_flight && abort[cur_q] && !wr_act;

    // A write stalled during the previous frame lands once the scheduler is back in idle.
    if (state_q == StIdle && sh_valid_q) begin
      id_d[cur_q]   = sh_id_q;
      data_d[cur_q] = sh_data_q;
      pend_d[cur_q] = 1'b1;
      sh_valid_d    = 1'b0;
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
      retry_d[cur_q] = '0;
`endif
    end

    unique case (state_q)
      StIdle: begin
        if (|pend_q && !tx_busy) state_d = StSelect;
      end
      StSelect: begin
        if (sel_valid) begin
          cur_d       = sel_idx;
          tx_id_d     = id_q[sel_idx];
          tx_data_d   = data_q[sel_idx];
          cur_abort_d = 1'b0;
          state_d     = StLaunch;
        end else begin
          state_d = StIdle;
        end
      end
      StLaunch: begin
        miss_d      = 1'b0;
        cur_abort_d = cur_abort_q | abort_cur;
        state_d     = StWait;
      end
      StWait: begin
        cur_abort_d = cur_abort_q | abort_cur;
        if (tx_done) begin
          fin           = 1'b1;
          fin_ok        = 1'b1;
          pend_d[cur_q] = 1'b0;
          state_d       = StIdle;
        end else if (tx_arb_lost || (miss_q && !tx_busy)) begin
          state_d = StIdle;
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
          if (32'(retry_q[cur_q]) + 32'd1 >= RETRY_MAX) retry_drop = 1'b1;
          else retry_d[cur_q] = retry_q[cur_q] + 4'd1;
`endif
          if (cur_abort_q || abort_cur || retry_drop) begin
            fin           = 1'b1;
            pend_d[cur_q] = 1'b0;
          end
        end else begin
          miss_d = !tx_busy;
        end
      end
      default: state_d = StIdle;
    endcase

    // Frame completions report directly; abort reports queue and drain lowest index first.
    pend_d = pend_d & ~abort_hit;
    queue  = rpt_q | abort_hit;
    rpt_d  = queue;
    if (fin) begin
      done_valid_d = 1'b1;
      done_idx_d   = cur_q;
      done_ok_d    = fin_ok;
    end else if (|queue) begin
      for (int i = int'(NUM_MB) - 1; i >= 0; i--) begin
        if (queue[i]) pick = IDX_W'(i);
      end
      rpt_d[pick]  = 1'b0;
      done_valid_d = 1'b1;
      done_idx_d   = pick;
      done_ok_d    = 1'b0;
    end

    if (wr_ok) begin
      if (wr_act) begin
        sh_valid_d = 1'b1;
        sh_id_d    = wr_id;
        sh_data_d  = wr_data;
      end else begin
        id_d[wr_sel]   = wr_id;
        data_d[wr_sel] = wr_data;
        pend_d[wr_sel] = 1'b1;
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
        retry_d[wr_sel] = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q      <= StIdle;
      id_q         <= '0;
      data_q       <= '0;
      pend_q       <= '0;
      rpt_q        <= '0;
      cur_q        <= '0;
      cur_abort_q  <= 1'b0;
      miss_q       <= 1'b0;
      sh_valid_q   <= 1'b0;
      sh_id_q      <= '0;
      sh_data_q    <= '0;
      tx_id_q      <= '0;
      tx_data_q    <= '0;
      done_valid_q <= 1'b0;
      done_idx_q   <= '0;
      done_ok_q    <= 1'b0;
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
      retry_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      data_q       <= data_d;
      pend_q       <= pend_d;
      rpt_q        <= rpt_d;
      cur_q        <= cur_d;
      cur_abort_q  <= cur_abort_d;
      miss_q       <= miss_d;
      sh_valid_q   <= sh_valid_d;
      sh_id_q      <= sh_id_d;
      sh_data_q    <= sh_data_d;
      tx_id_q      <= tx_id_d;
      tx_data_q    <= tx_data_d;
      done_valid_q <= done_valid_d;
      done_idx_q   <= done_idx_d;
      done_ok_q    <= done_ok_d;
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
      retry_q      <= retry_d;
`endif
    end
  end

  assign tx_start   = (state_q == StLaunch);
  assign tx_id      = tx_id_q;
  assign tx_data    = tx_data_q;
  assign mb_pending = pend_q;
  assign done_valid = done_valid_q;
  assign done_idx   = 3'(done_idx_q);
  assign done_ok    = done_ok_q;

endmodule
